ahb_arbiter: RTL and testbench
==============================

# ahb_arbiter

Round-robin bus arbiter that shares the single AHB interface among up to NUM_MASTERS `ahb_master` instances via their req/grant pair. It issues a one-hot grant, drives the bus-mux select `hmaster`, and holds ownership from grant through the end of the owner's transfer by observing the shared HTRANS/HREADY. If a granted master never starts a transfer within GRANT_TIMEOUT cycles, its grant is revoked.

## Interface
- NUM_MASTERS, default 4: number of requesters; legal range 2..16.
- GRANT_TIMEOUT, default 8: cycles a granted master may leave HTRANS[1]=0 before its grant is revoked; legal range 1..255.
- IDXW, default $clog2(NUM_MASTERS): width of `hmaster`.
- clk  in  1  bus clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_MASTERS  per-master request; held high until that master's transfer completes.
- HTRANS  in  2  shared bus transfer type, as driven by the currently muxed master.
- HREADY  in  1  shared bus ready from the slave.
- grant  out  NUM_MASTERS  one-hot grant; all zero when no owner.
- hmaster  out  IDXW  index of the owner or last owner; drives the HADDR/HTRANS/HWRITE/HWDATA mux.
- bus_busy  out  1  high in ARB_GRANT and ARB_BUSY.
- timeout_err  out  1  one-cycle pulse when a grant is revoked by timeout.

## Operation
- States: ARB_IDLE, ARB_GRANT (grant issued, waiting for address phase), ARB_BUSY (address phase seen, waiting for HREADY).
- Round-robin pointer `last` (IDXW bits). The winner is the first index with req=1, searching cyclically from last+1.
- ARB_IDLE:
  - Any req high: grant[winner]<=1, hmaster<=winner, timeout counter<=0, go to ARB_GRANT.
  - Otherwise stay; grant stays 0; hmaster holds its value.
- ARB_GRANT:
  - HTRANS[1]=1 and HREADY=1: transfer complete. grant<=0, last<=hmaster, go to ARB_IDLE.
  - HTRANS[1]=1 and HREADY=0: go to ARB_BUSY.
  - HTRANS[1]=0 and req[hmaster]=0: the master withdrew. grant<=0, last<=hmaster, go to ARB_IDLE.
  - HTRANS[1]=0 with counter = GRANT_TIMEOUT-1: grant<=0, timeout_err<=1, last<=hmaster, go to ARB_IDLE.
  - Otherwise: counter+1 (8-bit, saturating).
- ARB_BUSY:
  - HREADY=1: grant<=0, last<=hmaster, go to ARB_IDLE.
  - req changes are ignored; the transfer is never aborted.
- After every release the arbiter spends exactly one cycle in ARB_IDLE with grant=0. This dead cycle lets the previous owner's req fall, so it is not re-granted.
- Only one grant bit is ever high. HTRANS=BUSY (01) counts as "not started".
- Out-of-range req bits are ignored (there are none when NUM_MASTERS is a power of two).

## Timing
- Reset (asynchronous, immediate):
  - state=ARB_IDLE, grant=0, hmaster=0, bus_busy=0, timeout_err=0, counter=0.
  - last=NUM_MASTERS-1, so master 0 has first priority.
- Outputs are registered; no combinational path from inputs to outputs.
- Request-to-grant latency: req sampled high at edge N gives grant high after edge N.
- Master protocol: the master samples grant at edge N+1 and drives HTRANS=NONSEQ after N+1. With zero-wait HREADY the arbiter releases at edge N+2.
- Minimum request-to-request spacing on the bus is 3 cycles: grant, address phase, dead cycle.
- Timeout: grant drops GRANT_TIMEOUT edges after the entry to ARB_GRANT. timeout_err is high for exactly the cycle after that edge.
- Reset asserted mid-transfer: all outputs return to reset values immediately; no pending state survives.
- Simultaneous release and new request: the new request is not granted on the release edge. It is granted on the following edge, from ARB_IDLE.

## Test plan
- Reset: rst_n=0 mid-ARB_BUSY with grant=4'b0100 -> grant=0, hmaster=0, bus_busy=0 immediately; after release, req=4'b1111 gives grant=4'b0001 first.
- Single master 2, zero-wait slave: write to addr 0x0000_1000 with data 0xDEAD_BEEF.
  - Grant=4'b0100 one cycle after req; HTRANS=10 seen next cycle; grant drops on the HREADY edge.
  - Exactly one dead cycle follows; the slave sees the correct HADDR/HWDATA via hmaster=2.
- Round robin: req=4'b1111 held by all masters, each doing one transfer.
  - Grant order 0,1,2,3,0.
  - Each grant is one-hot and separated by one all-zero cycle.
- Wait states: master 1 read with HREADY held low for 3 cycles.
  - State stays ARB_BUSY; grant=4'b0010 throughout, even if req[3] rises mid-transfer.
  - Master 3 is granted 2 cycles after HREADY=1.
- Timeout: GRANT_TIMEOUT=4, master 0 forced to keep HTRANS=00 with req high.
  - Grant drops after 4 cycles; timeout_err pulses for 1 cycle.
  - Pending req[1] is granted next, from ARB_IDLE.
- Withdrawal: master 3 is granted, then drops req before driving HTRANS -> grant=0 next edge, no timeout_err, last=3, so req[0] wins the next arbitration.

Source files
------------

// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter: one-hot grant, hmaster mux select, ownership held
// from grant through the end of the owner's transfer, with grant timeout.
module ahb_arbiter #(
  parameter int NUM_MASTERS   = 4,
  parameter int GRANT_TIMEOUT = 8,
  parameter int IDXW          = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [1:0]             HTRANS,
  input  logic                   HREADY,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [IDXW-1:0]        hmaster,
  output logic                   bus_busy,
  output logic                   timeout_err
);

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_BUSY
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(GRANT_TIMEOUT - 1);

  state_t                 state, state_d;
  logic [NUM_MASTERS-1:0] grant_d;
  logic [IDXW-1:0]        hmaster_d;
  logic [IDXW-1:0]        last, last_d;
  logic [IDXW-1:0]        winner, cand;
  logic                   found;
  logic [7:0]             cnt, cnt_d;
  logic                   timeout_d;
  logic                   htrans_seq_unused;

  // Only HTRANS[1] distinguishes a started transfer; IDLE and BUSY both mean "not started".
  assign htrans_seq_unused = HTRANS[0];

  assign bus_busy = (state != ARB_IDLE);

  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = IDXW'((int'(last) + i) % NUM_MASTERS);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_d   = state;
    grant_d   = grant;
    hmaster_d = hmaster;
    last_d    = last;
    cnt_d     = cnt;
    timeout_d = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (found) begin
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          hmaster_d       = winner;
          cnt_d           = '0;
          state_d         = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (HTRANS[1]) begin
          if (HREADY) begin
            grant_d = '0;
            last_d  = hmaster;
            state_d = ARB_IDLE;
          end else begin
            state_d = ARB_BUSY;
          end
        end else if (!req[hmaster]) begin
          grant_d = '0;
          last_d  = hmaster;
          state_d = ARB_IDLE;
        end else if (cnt == CNT_LAST) begin
          grant_d   = '0;
          last_d    = hmaster;
          timeout_d = 1'b1;
          state_d   = ARB_IDLE;
        end else if (cnt != 8'hFF) begin
          cnt_d = cnt + 8'd1;
        end
      end
      ARB_BUSY: begin
        // Once the address phase is out the transfer always completes.
        if (HREADY) begin
          grant_d = '0;
          last_d  = hmaster;
          state_d = ARB_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARB_IDLE;
      grant       <= '0;
      hmaster     <= '0;
      last        <= IDXW'(NUM_MASTERS - 1);
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      grant       <= grant_d;
      hmaster     <= hmaster_d;
      last        <= last_d;
      cnt         <= cnt_d;
      timeout_err <= timeout_d;
    end
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: grant events are checked by a scoreboard monitor,
// cycle-exact timing by direct checks after each clock edge.
module tb_ahb_arbiter;

  typedef struct {
    bit         is_timeout;
    logic [3:0] grant;
    logic [1:0] hm;
  } sb_item_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  req;
  logic [1:0]  HTRANS;
  logic        HREADY;
  logic [3:0]  grant;
  logic [1:0]  hmaster;
  logic        bus_busy;
  logic        timeout_err;

  int          compared = 0;
  int          mismatched = 0;
  sb_item_t    exp_q[$];
  logic [3:0]  prev_grant = 4'b0000;
  logic [31:0] haddr_of [4];
  logic [31:0] hwdata_of [4];

  ahb_arbiter #(.NUM_MASTERS(4), .GRANT_TIMEOUT(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .HTRANS(HTRANS),
    .HREADY(HREADY),
    .grant(grant),
    .hmaster(hmaster),
    .bus_busy(bus_busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [3:0] r, input logic [1:0] ht, input logic hr);
    req    = r;
    HTRANS = ht;
    HREADY = hr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] eg, input logic [1:0] eh,
                             input logic eb, input logic et);
    compared++;
    if ({grant, hmaster, bus_busy, timeout_err} !== {eg, eh, eb, et}) begin
      mismatched++;
      $display("[TB] FAIL %s: got grant=%b hmaster=%0d bus_busy=%b timeout_err=%b, want grant=%b hmaster=%0d bus_busy=%b timeout_err=%b",
               name, grant, hmaster, bus_busy, timeout_err, eg, eh, eb, et);
    end
  endtask

  task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic pushGrant(input int m);
    sb_item_t e;
    e.is_timeout = 1'b0;
    e.grant      = 4'(1 << m);
    e.hm         = 2'(m);
    exp_q.push_back(e);
  endtask

  task automatic pushTimeout();
    sb_item_t e;
    e.is_timeout = 1'b1;
    e.grant      = 4'b0000;
    e.hm         = 2'b00;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: every fresh grant and every timeout pulse consumes one expectation.
  always @(negedge clk) begin
    sb_item_t e;
    if (rst_n) begin
      if (grant != 4'b0000 && prev_grant == 4'b0000) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL sb grant: got unexpected grant=%b hmaster=%0d, want none", grant, hmaster);
        end else begin
          e = exp_q.pop_front();
          if (e.is_timeout || grant !== e.grant || hmaster !== e.hm) begin
            mismatched++;
            $display("[TB] FAIL sb grant: got grant=%b hmaster=%0d, want grant=%b hmaster=%0d timeout=%b",
                     grant, hmaster, e.grant, e.hm, e.is_timeout);
          end
        end
      end
      if (timeout_err) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL sb timeout: got unexpected timeout_err=1, want none");
        end else begin
          e = exp_q.pop_front();
          if (!e.is_timeout) begin
            mismatched++;
            $display("[TB] FAIL sb timeout: got timeout_err=1, want grant=%b hmaster=%0d", e.grant, e.hm);
          end
        end
      end
    end
    prev_grant = grant;
  end

  initial begin
    int         order [5];
    logic [3:0] r;
    order = '{0, 1, 2, 3, 0};
    haddr_of  = '{32'h0000_0100, 32'h0000_0200, 32'h0000_1000, 32'h0000_0300};
    hwdata_of = '{32'h1111_1111, 32'h2222_2222, 32'hDEAD_BEEF, 32'h3333_3333};
    req    = 4'b0000;
    HTRANS = 2'b00;
    HREADY = 1'b1;
    #1 rst_n = 1'b0;
    #1 checkOutput("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset while master 2 is in its address phase with HREADY low
    pushGrant(2);
    applyStimulus(4'b0100, 2'b00, 1'b1);
    checkOutput("pre-reset grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    applyStimulus(4'b0100, 2'b10, 1'b0);
    checkOutput("pre-reset busy", 4'b0100, 2'd2, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 checkOutput("async reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    req    = 4'b1111;
    HTRANS = 2'b00;
    HREADY = 1'b1;
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Round robin with all four requesting; master 0 re-requests after master 3
    for (int k = 0; k < 5; k++) pushGrant(order[k]);
    r = 4'b1111;
    applyStimulus(r, 2'b00, 1'b1);
    checkOutput("rr first", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      int m;
      m = order[k];
      applyStimulus(r, 2'b00, 1'b1);
      checkOutput("rr hold", 4'(1 << m), 2'(m), 1'b1, 1'b0);
      applyStimulus(r, 2'b10, 1'b1);
      checkOutput("rr release", 4'b0000, 2'(m), 1'b0, 1'b0);
      r[m] = 1'b0;
      if (k == 3) r[0] = 1'b1;
      applyStimulus(r, 2'b00, 1'b1);
      if (k < 4) checkOutput("rr next", 4'(1 << order[k+1]), 2'(order[k+1]), 1'b1, 1'b0);
      else       checkOutput("rr idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    end

    // Single master 2 write, zero-wait slave
    pushGrant(2);
    applyStimulus(4'b0100, 2'b00, 1'b1);
    checkOutput("single grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    applyStimulus(4'b0100, 2'b00, 1'b1);
    checkOutput("single hold", 4'b0100, 2'd2, 1'b1, 1'b0);
    checkValue("single haddr", haddr_of[hmaster], 32'h0000_1000);
    applyStimulus(4'b0100, 2'b10, 1'b1);
    checkOutput("single release", 4'b0000, 2'd2, 1'b0, 1'b0);
    checkValue("single hwdata", hwdata_of[hmaster], 32'hDEAD_BEEF);
    applyStimulus(4'b0000, 2'b00, 1'b1);
    checkOutput("single dead", 4'b0000, 2'd2, 1'b0, 1'b0);

    // Master 1 read with three wait states; master 3 requests mid-transfer
    pushGrant(1);
    pushGrant(3);
    applyStimulus(4'b0010, 2'b00, 1'b1);
    checkOutput("ws grant", 4'b0010, 2'd1, 1'b1, 1'b0);
    applyStimulus(4'b0010, 2'b00, 1'b1);
    checkOutput("ws hold", 4'b0010, 2'd1, 1'b1, 1'b0);
    applyStimulus(4'b0010, 2'b10, 1'b0);
    checkOutput("ws busy 0", 4'b0010, 2'd1, 1'b1, 1'b0);
    applyStimulus(4'b1010, 2'b00, 1'b0);
    checkOutput("ws busy 1", 4'b0010, 2'd1, 1'b1, 1'b0);
    applyStimulus(4'b1010, 2'b00, 1'b0);
    checkOutput("ws busy 2", 4'b0010, 2'd1, 1'b1, 1'b0);
    applyStimulus(4'b1010, 2'b00, 1'b1);
    checkOutput("ws release", 4'b0000, 2'd1, 1'b0, 1'b0);
    applyStimulus(4'b1000, 2'b00, 1'b1);
    checkOutput("ws grant m3", 4'b1000, 2'd3, 1'b1, 1'b0);
    applyStimulus(4'b1000, 2'b00, 1'b1);
    applyStimulus(4'b1000, 2'b10, 1'b1);
    checkOutput("m3 release", 4'b0000, 2'd3, 1'b0, 1'b0);

    // Master 0 granted but never starts; req[1] pending
    pushGrant(0);
    pushTimeout();
    pushGrant(1);
    applyStimulus(4'b0011, 2'b00, 1'b1);
    checkOutput("to grant", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(4'b0011, 2'b01, 1'b1);
      checkOutput("to hold", 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    applyStimulus(4'b0011, 2'b00, 1'b1);
    checkOutput("to revoke", 4'b0000, 2'd0, 1'b0, 1'b1);
    applyStimulus(4'b0011, 2'b00, 1'b1);
    checkOutput("to next", 4'b0010, 2'd1, 1'b1, 1'b0);
    applyStimulus(4'b0011, 2'b00, 1'b1);
    applyStimulus(4'b0011, 2'b10, 1'b1);
    checkOutput("to m1 release", 4'b0000, 2'd1, 1'b0, 1'b0);

    // Master 3 withdraws before its address phase
    pushGrant(3);
    pushGrant(0);
    pushGrant(2);
    applyStimulus(4'b1000, 2'b00, 1'b1);
    checkOutput("wd grant", 4'b1000, 2'd3, 1'b1, 1'b0);
    applyStimulus(4'b0101, 2'b00, 1'b1);
    checkOutput("wd drop", 4'b0000, 2'd3, 1'b0, 1'b0);
    applyStimulus(4'b0101, 2'b00, 1'b1);
    checkOutput("wd next", 4'b0001, 2'd0, 1'b1, 1'b0);
    applyStimulus(4'b0101, 2'b00, 1'b1);
    applyStimulus(4'b0101, 2'b10, 1'b1);
    checkOutput("wd m0 release", 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(4'b0100, 2'b00, 1'b1);
    checkOutput("wd m2 grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    applyStimulus(4'b0100, 2'b00, 1'b1);
    applyStimulus(4'b0100, 2'b10, 1'b1);
    applyStimulus(4'b0000, 2'b00, 1'b1);
    checkOutput("final idle", 4'b0000, 2'd2, 1'b0, 1'b0);
    repeat (3) applyStimulus(4'b0000, 2'b00, 1'b1);

    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL sb drain: got %0d pending events, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
